// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the default operand width.
package serial_add_pkg;

    localparam int unsigned SA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sa_state_t;

endpackage

// File: rtl/bit_full_add.sv
// Combinational 1-bit full adder built from two half-adder stages plus an OR;
// this is the cell time-shared by serial_add_ctrl.
module bit_full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    half_add u_ha0 (
        .a (a),
        .b (b),
        .s (w_s1),
        .c (w_c1)
    );

    half_add u_ha1 (
        .a (w_s1),
        .b (cin),
        .s (sum),
        .c (w_c2)
    );

    assign cout = w_c1 | w_c2;

endmodule

// File: rtl/half_add.sv
// Single half-adder stage: sum and carry of two bits.
module half_add (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: captures two WIDTH-bit operands on start, steps
// one shared full-adder cell LSB first, and presents a registered sum/carry.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SA_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    sa_state_t        r_state;
    sa_state_t        w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_cy;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;

    bit_full_add u_fa (
        .a    (r_a_sh[0]),
        .b    (r_b_sh[0]),
        .cin  (r_cy),
        .sum  (w_fa_sum),
        .cout (w_fa_cout)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at index 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_cnt   <= '0;
            r_cy    <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh <= a_in;
                        r_b_sh <= b_in;
                        r_s_sh <= '0;
                        r_cnt  <= '0;
                        r_cy   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_s_sh <= {w_fa_sum, r_s_sh[WIDTH-1:1]};
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cy   <= w_fa_cout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_sum   <= {w_fa_sum, r_s_sh[WIDTH-1:1]};
                        r_carry <= w_fa_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);
    assign sum_out   = r_sum;
    assign carry_out = r_carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random self-checking bench for serial_add_ctrl at WIDTH=8.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] sum_out;
    logic       carry_out;

    int checks   = 0;
    int failures = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation; leaves the bench in the first IDLE cycle afterwards.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [8:0] exp, input string tag);
        int lat;
        int busy_cnt;
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        step();
        start = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!done && lat < 20) begin
            if (busy) busy_cnt++;
            step();
            lat++;
        end
        chk({tag, ".latency"}, lat, 8);
        chk({tag, ".busy_cycles"}, busy_cnt, 8);
        chk({tag, ".busy_in_done"}, {31'd0, busy}, 0);
        chk({tag, ".result"}, {23'd0, carry_out, sum_out}, {23'd0, exp});
        step();
        chk({tag, ".done_width"}, {31'd0, done}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        logic [7:0] ra;
        logic [7:0] rb;

        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        step();
        step();
        chk("reset.busy", {31'd0, busy}, 0);
        chk("reset.done", {31'd0, done}, 0);
        chk("reset.sum", {24'd0, sum_out}, 0);
        chk("reset.carry", {31'd0, carry_out}, 0);
        rst = 1'b0;
        step();

        do_op(8'd3,   8'd5,   9'd8,     "add_3_5");
        do_op(8'd255, 8'd1,   9'h100,   "ovf_255_1");
        do_op(8'd255, 8'd255, 9'h1FE,   "ovf_255_255");
        do_op(8'd0,   8'd0,   9'h000,   "zero");
        do_op(8'd170, 8'd85,  9'h0FF,   "b2b_170_85");

        // Start pulses and operand changes during RUN and DONE are ignored.
        a_in  = 8'h12;
        b_in  = 8'h34;
        start = 1'b1;
        step();
        done_cnt = 0;
        for (int i = 0; i < 9; i++) begin
            a_in  = 8'hFF;
            b_in  = 8'hFF;
            start = 1'b1;
            if (i == 3) chk("ignore.held_prev", {23'd0, carry_out, sum_out}, 32'h0FF);
            if (done) done_cnt++;
            step();
        end
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_cnt++;
            step();
        end
        chk("ignore.done_count", done_cnt, 1);
        chk("ignore.result", {23'd0, carry_out, sum_out}, 32'h046);
        chk("ignore.idle_busy", {31'd0, busy}, 0);

        // Reset at RUN cycle 4 aborts without a done pulse.
        a_in  = 8'hF0;
        b_in  = 8'h0F;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("abort.busy_before", {31'd0, busy}, 1);
        rst = 1'b1;
        step();
        chk("abort.busy", {31'd0, busy}, 0);
        chk("abort.done", {31'd0, done}, 0);
        chk("abort.sum", {24'd0, sum_out}, 0);
        chk("abort.carry", {31'd0, carry_out}, 0);
        start = 1'b1;
        step();
        chk("rst_start.busy", {31'd0, busy}, 0);
        rst   = 1'b0;
        start = 1'b0;
        step();
        chk("rst_start.idle_done", {31'd0, done}, 0);
        do_op(8'd100, 8'd27, 9'd127, "after_abort");

        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op(ra, rb, {1'b0, ra} + {1'b0, rb}, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
